attosoc_uart_tx: RTL
====================

Name: attosoc_uart_tx

Overview:
- Byte-serial UART transmitter (8N1) placed directly downstream of the attosoc core on the ULX3S board.
- Takes byte writes from the SoC bus side through a small FIFO.
- Drives the serial line that the top-level I/O wrapper routes to the gpio0 output buffer (LVCMOS33) in place of the current constant-high tie-off.
- Runs in the same clock domain as the soc, which is the divided board clock.

Parameters:
- CLK_DIV, 54, clk cycles per UART bit; legal range is 2 or more (54 gives ~115200 baud at 6.25 MHz).
- FIFO_DEPTH, 4, byte FIFO entries; must be a power of two and 2 or more.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- resetn  input  1  synchronous reset, active-low.
- wr_valid  input  1  write request from the SoC side.
- wr_data  input  8  byte to transmit; sampled when wr_valid && wr_ready.
- wr_ready  output  1  FIFO can accept a byte this cycle.
- tx  output  1  serial line to the pin buffer; idle high.
- busy  output  1  frame in progress or FIFO non-empty.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  registered count of bytes held in the FIFO.

Behaviour:
- Reset (resetn low at a rising edge):
  - tx=1, fifo_level=0, busy=0, FSM=IDLE.
  - Bit/baud counters and read/write pointers are cleared.
  - wr_ready=0 while resetn is low.
- Reset mid-frame aborts the frame: tx is high from the first reset edge, FIFO contents are discarded, and nothing resumes after release.
- Write handshake:
  - A push occurs when wr_valid && wr_ready at an edge.
  - wr_ready = resetn && (fifo_level != FIFO_DEPTH). It depends only on registered state, never on wr_valid.
  - If the master holds wr_valid while wr_ready=0, nothing is written. The master must hold data stable; no byte is lost or duplicated.
- Pop: the FSM pops the head byte at an edge where it loads a frame (see below).
- Simultaneous push and pop at one edge: fifo_level is unchanged and both operations complete.
- A byte pushed at edge E is not visible to the FSM before edge E+1.
- fifo_level never exceeds FIFO_DEPTH and never underflows.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
- FSM states and transitions:
  - IDLE: tx=1. At an edge with fifo_level != 0: pop, load the shift register, tx<=0, baud counter<=0, go to START.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] (LSB first). Each bit lasts CLK_DIV cycles, then shift right and increment the index. After bit 7 completes, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. On the final stop cycle edge:
    - if fifo_level != 0: pop and go directly to START with tx<=0, giving no idle gap;
    - otherwise go to IDLE.
- Timing:
  - Every frame lasts exactly 10*CLK_DIV cycles.
  - Back-to-back frames repeat exactly every 10*CLK_DIV cycles.
  - With the FSM in IDLE and the FIFO empty, a byte accepted at edge E gives tx=0 from edge E+1.
- Baud counter: $clog2(CLK_DIV) bits, counts 0..CLK_DIV-1, and wraps to 0 at each bit boundary.
- busy = (FSM != IDLE) || (fifo_level != 0). It is registered-state based and falls on the same edge the FSM enters IDLE with the FIFO empty.
- tx is driven directly from a flop, giving a glitch-free pin.

Test Plan:
1. Reset: hold resetn=0 for 3 cycles with wr_valid=1 -> tx=1, busy=0, fifo_level=0, wr_ready=0 throughout and no byte accepted. After release, wr_ready=1.
2. Single byte, CLK_DIV=4: push 0xA5 at edge E with the FIFO empty -> tx=0 over edges E+1..E+4, then data 1,0,1,0,0,1,0,1 (4 cycles each), stop=1 for 4 cycles. busy falls at E+41; tx stays 1 afterward.
3. Back-pressure, CLK_DIV=4, FIFO_DEPTH=4: push 0x55; while it is transmitting, push 0x01..0x04 and hold 0x05 -> level reaches 4 and wr_ready=0. 0x05 is accepted on the edge after the first pop. Serial output is 0x55,0x01..0x05 with frames exactly 40 cycles apart and no idle cycles.
4. Simultaneous push/pop: level=1 at the final STOP edge, push 0x7E that same edge -> level stays 1, next frame starts immediately, and 0x7E is transmitted after it.
5. Reset mid-frame: assert resetn=0 for 1 cycle during data bit 3 of 0xC3 with 2 bytes queued -> tx=1 from the reset edge and level=0. After release, push 0x3C -> clean frame 0x3C only.
6. Pointer wrap: stream 10 bytes 0x00..0x09 with wr_valid held high -> all 10 are received in order with none dropped or duplicated, and fifo_level never exceeds 4.

Source files
------------

// File: rtl/attosoc_uart_tx.sv
// attosoc_uart_tx
//   8N1 UART transmitter fed by a small byte FIFO. It sits next to the attosoc
//   core in the divided-clock domain and drives the gpio0 serial pin.
//
// Ports
//   clk        : system clock, all state changes on its rising edge
//   resetn     : synchronous reset, active-low
//   wr_valid   : SoC-side write request
//   wr_data    : byte to send, taken when wr_valid && wr_ready
//   wr_ready   : FIFO has room this cycle (low while in reset)
//   tx         : serial output, idle high, straight from a flop
//   busy       : a frame is on the line or bytes are still queued
//   fifo_level : registered number of bytes held in the FIFO
module attosoc_uart_tx #(
  parameter int CLK_DIV    = 54,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLK_DIV);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic [PTR_W-1:0]    wptr_q, wptr_d;
  logic [PTR_W-1:0]    rptr_q, rptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [7:0]          mem_q [FIFO_DEPTH];

  logic                push;
  logic                pop;
  logic                fifo_nonempty;
  logic                baud_end;

  // Ready only looks at registered state and reset, never at wr_valid.
  assign wr_ready      = resetn && (level_q != LVL_FULL);
  assign push          = wr_valid && wr_ready;
  assign fifo_nonempty = (level_q != '0);
  assign baud_end      = (baud_q == BAUD_LAST);

  // Frame sequencer. The FSM only sees the registered level, so a byte
  // pushed on an edge cannot be popped before the following edge.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // Present the next bit now so tx stays a pure flop output.
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (fifo_nonempty) begin
            // Chain straight into the next start bit: no idle gap.
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO bookkeeping; a simultaneous push and pop leaves the level alone.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
    busy_d = (state_d != IDLE) || (level_d != '0);
  end

  // Control state: cleared by reset, which also aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
    end
  end

  // Datapath storage: contents are don't-care until the pointers qualify them.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;

endmodule
